// File: rtl/vc32_bus_responder.sv
// ---------------------------------------------------------------------------
// vc32_bus_responder
//
// Byte-wide memory and interrupt responder for the VC32 CPU's multiplexed
// bus. The CPU sends a 22-bit byte address in three phases (HI, MID, LO),
// then writes or reads bytes. The ind strobe selects the low (0) or high (1)
// byte of the addressed halfword.
//
// Ports:
//   clk      in   1  rising-edge clock shared with the CPU
//   rst_n    in   1  asynchronous active-low reset
//   bus_in   in   8  address / write-data byte from the CPU
//   strb     in   4  {latch_lo, latch_hi, write, ind}
//   bus_out  out  8  combinational read-data byte to the CPU
//   irq      out  1  level interrupt request (set by writing IRQ_ADDR)
//   err      out  1  sticky protocol-error flag (only with VC32_RESP_CHECK_EN)
//
// Build option: define VC32_RESP_CHECK_EN to add the err port and its checker.
// ---------------------------------------------------------------------------
module vc32_bus_responder #(
    parameter int          AW       = 10,
    parameter logic [21:0] IRQ_ADDR = 22'h3FFFFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] bus_in,
    input  logic [3:0] strb,
    output logic [7:0] bus_out,
    output logic       irq
`ifdef VC32_RESP_CHECK_EN
    ,
    output logic       err
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_HI, ST_MID, ST_ADDR} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [21:1] r_addr;          // addr[0] is never stored; ind supplies it
    logic [21:1] w_addr_nxt;
    logic        r_seq_ok;        // a legal HI-MID-LO chain led to ADDR
    logic        w_seq_ok_nxt;
    logic        r_irq;
    logic        w_illegal;
    logic        w_write_ok;
    logic [7:0]  r_mem [2**AW];

    logic        w_lo, w_hi, w_wr, w_ind;
    logic [7:1]  w_a71;
    logic [21:0] w_eff_addr;
    logic [21:0] w_wr_addr;
    logic        w_eff_in_mem, w_eff_is_irq;
    logic        w_wr_in_mem, w_wr_is_irq;

    assign w_lo  = strb[3];
    assign w_hi  = strb[2];
    assign w_wr  = strb[1];
    assign w_ind = strb[0];

    // The low address bits bypass the register during the LO strobe so the
    // CPU can sample the low byte in the same cycle it sends the address.
    assign w_a71      = (w_lo && !w_hi) ? bus_in[7:1] : r_addr[7:1];
    assign w_eff_addr = rst_n ? {r_addr[21:8], w_a71, w_ind} : {21'b0, w_ind};
    assign w_wr_addr  = {r_addr, w_ind};

    // Full decode of the bits above AW: nothing aliases into the memory.
    assign w_eff_in_mem = (w_eff_addr >> AW) == 22'd0;
    assign w_eff_is_irq = (w_eff_addr == IRQ_ADDR);
    assign w_wr_in_mem  = (w_wr_addr >> AW) == 22'd0;
    assign w_wr_is_irq  = (w_wr_addr == IRQ_ADDR);

    // Next-state and command decode.
    // NOTE: every output of this block gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_seq_ok_nxt = r_seq_ok;
        w_illegal    = 1'b0;
        w_write_ok   = 1'b0;
        if (w_wr && (w_hi || w_lo)) begin
            // write-plus-latch is rejected outright: nothing moves
            w_illegal = 1'b1;
        end else if (w_hi && !w_lo) begin
            w_addr_nxt[21:16] = bus_in[5:0];
            w_state_nxt       = ST_HI;
            w_seq_ok_nxt      = 1'b1;
        end else if (w_hi && w_lo) begin
            w_addr_nxt[15:8] = bus_in;
            w_state_nxt      = ST_MID;
            if (r_state != ST_HI) begin
                w_illegal    = 1'b1;
                w_seq_ok_nxt = 1'b0;
            end
        end else if (w_lo) begin
            w_addr_nxt[7:1] = bus_in[7:1];
            w_state_nxt     = ST_ADDR;
            if (r_state != ST_MID) begin
                w_illegal    = 1'b1;
                w_seq_ok_nxt = 1'b0;
            end
        end else if (w_wr) begin
            // an ADDR reached through a broken chain still refuses writes
            if (r_state == ST_ADDR) begin
                w_write_ok = r_seq_ok;
            end else begin
                w_illegal = 1'b1;
            end
        end else if (!w_ind) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_seq_ok <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_addr   <= w_addr_nxt;
            r_seq_ok <= w_seq_ok_nxt;
            if (w_write_ok && w_wr_is_irq) begin
                r_irq <= |bus_in;
            end
        end
    end

    // NOTE: the memory array has no reset; its contents survive rst_n.
    // Writes cannot occur in reset because r_state is held in ST_IDLE.
    always_ff @(posedge clk) begin
        if (w_write_ok && w_wr_in_mem) begin
            r_mem[w_wr_addr[AW-1:0]] <= bus_in;
        end
    end

    always_comb begin
        bus_out = 8'hFF;
        if (w_eff_in_mem) begin
            bus_out = r_mem[w_eff_addr[AW-1:0]];
        end else if (w_eff_is_irq) begin
            bus_out = {7'b0, r_irq};
        end
    end

    assign irq = r_irq;

`ifdef VC32_RESP_CHECK_EN
    logic r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_illegal) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif

endmodule

// File: doc/vc32_bus_responder.md
VC32_BUS_RESPONDER -- requirements
Module: vc32_bus_responder

Interface
REQ-001 Parameter AW, default 10: backing memory holds 2^AW bytes at byte addresses 0..2^AW-1.
REQ-002 Parameter IRQ_ADDR, default 22'h3FFFFF: byte address of the interrupt register.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset; the ports are named clk and rst_n.
REQ-004 clk  in  1  rising-edge clock shared with the CPU.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 bus_in  in  8  multiplexed address/write-data byte from the CPU (CPU uo_out).
REQ-007 strb  in  4  {latch_lo, latch_hi, write, ind}, the same bit order as CPU uio_out[3:0].
REQ-008 bus_out  out  8  read-data byte to the CPU (CPU ui_in).
REQ-009 irq  out  1  level interrupt request to the CPU (uio_in[7]).
REQ-010 err  out  1  sticky protocol-error flag; present only with VC32_RESP_CHECK_EN.

Function
REQ-011 Phase FSM states: IDLE, HI, MID, ADDR; all transitions occur on the rising edge of clk.
REQ-012 latch_hi=1, latch_lo=0: addr[21:16] <= bus_in[5:0]; next state HI, from any state.
REQ-013 latch_hi=1, latch_lo=1: addr[15:8] <= bus_in; next state MID.
REQ-014 latch_hi=0, latch_lo=1: addr[7:1] <= bus_in[7:1]; bus_in[0] is ignored; next state ADDR.
REQ-015 write=1 with both latches 0 in state ADDR: store bus_in at byte address {addr[21:1], ind}; state stays ADDR so a following high-byte write (ind=1) is accepted.
REQ-016 All four strb bits 0: next state IDLE; no storage change.
REQ-017 bus_out SHALL be combinational from the effective byte address {addr[21:8], A71, ind}.
REQ-018 A71 = bus_in[7:1] while latch_lo=1 and latch_hi=0, otherwise addr[7:1]; this lets the CPU sample the low byte in the same cycle as the low-address strobe and the high byte in the next cycle with ind=1.
REQ-019 Effective address < 2^AW: bus_out = memory byte.
REQ-020 Effective address == IRQ_ADDR: bus_out = {7'b0, irq}.
REQ-021 Any other address: bus_out = 8'hFF, and writes to it SHALL be dropped.
REQ-022 A write to IRQ_ADDR SHALL set irq <= |bus_in on the same edge, so irq is visible from the next cycle.
REQ-023 A write followed by a read of the same byte in the next cycle SHALL return the new value, with no bypass stall.
REQ-024 Illegal combinations SHALL cause no storage or irq change:
- write=1 together with latch_hi or latch_lo;
- write=1 in a state other than ADDR;
- latch_hi=1 with latch_lo=1 when the state is not HI;
- latch_lo=1 only when the state is not MID.
The FSM and address register still update per REQ-012..REQ-014, except that write-plus-latch SHALL update nothing.
REQ-025 Address upper bits beyond AW SHALL be fully decoded; there is no aliasing or wrap-around into memory.

Reset
REQ-026 rst_n low SHALL asynchronously force: state IDLE, addr 0, irq 0, err 0.
REQ-027 Memory contents are not reset.
REQ-028 Reset asserted mid-transaction aborts the transaction; after release, writes are refused until a full HI-MID-ADDR sequence completes.
REQ-029 During reset, bus_out SHALL equal the byte at address {21'b0, ind}.

Configuration
REQ-030 Macro VC32_RESP_CHECK_EN defined: port err exists and is set to 1 by any REQ-024 illegal combination; it is cleared only by rst_n.
REQ-031 Macro undefined: the err port and its checker logic are absent; illegal combinations still follow REQ-024.

Verification
REQ-032 Write word 16'hBEEF to address 22'h000124 (HI 00, MID 01, LO 24, write ind=0 EF, write ind=1 BE) -> bytes 0x124=EF and 0x125=BE.
REQ-033 Read of 22'h000124: in the LO cycle bus_out=EF; in the next cycle with ind=1, bus_out=BE.
REQ-034 Byte write of 8'h01 to IRQ_ADDR -> irq=1 from the next cycle and a read of IRQ_ADDR returns 01; a write of 8'h00 -> irq=0.
REQ-035 Read of 22'h010000 -> bus_out=FF; a write to it leaves memory byte 0 unchanged.
REQ-036 Write strobe issued after HI only -> no memory change; err=1 when the macro is defined.
REQ-037 rst_n pulsed low between MID and LO, then LO and write -> write refused; err=1 when defined; irq=0.
